// File: rtl/rtl_regfile_sb.sv
// rtl/rtl_regfile_sb.sv - multi-port GPR file with busy scoreboard and post-reset clear sweep

module rtl_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_done,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_set_addr,
    output logic [NREG-1:0]      busy_vec,
    output logic                 wr_conflict
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] CLR_LAST = AW'(NREG - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic                wr_conflict_q, wr_conflict_d;
    logic [XLEN-1:0]     mem_q [NREG];

    logic                run;
    logic [AW-1:0]       waddr_a [NWR];
    logic [XLEN-1:0]     wdata_a [NWR];
    logic [NWR-1:0]      wr_valid;
    logic [AW-1:0]       raddr_a [NRD];
    logic [XLEN-1:0]     rd_val  [NRD];
    logic [NRD-1:0]      rd_hit;

    // Addresses beyond the last register neither read nor write.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return int'(a) < NREG;
    endfunction

    // True when the address is the hard-wired zero register.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign run         = (state_q == ST_RUN);
    assign init_done   = run;
    assign busy_vec    = busy_q;
    assign wr_conflict = wr_conflict_q;

    // Unpack write ports and qualify them: only real, in-range, non-x0 writes in RUN count.
    always_comb begin
        for (int k = 0; k < NWR; k++) begin
            waddr_a[k]  = waddr[k*AW +: AW];
            wdata_a[k]  = wdata[k*XLEN +: XLEN];
            wr_valid[k] = run && we[k] && addr_ok(waddr_a[k]) && !is_zero(waddr_a[k]);
        end
    end

    // Sweep sequencing: CLEAR walks every entry once, then the file is usable.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Sticky flag for two effective writes to one address in the same cycle.
    always_comb begin
        wr_conflict_d = wr_conflict_q;
        for (int k = 0; k < NWR; k++) begin
            for (int m = k + 1; m < NWR; m++) begin
                if (wr_valid[k] && wr_valid[m] && (waddr_a[k] == waddr_a[m])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; set applied last so a newer producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_valid[k]) begin
                busy_d[waddr_a[k]] = 1'b0;
            end
        end
        if (run && sb_set && addr_ok(sb_set_addr) && !is_zero(sb_set_addr)) begin
            busy_d[sb_set_addr] = 1'b1;
        end
    end

    // Control state with asynchronous reset; a reset mid-sweep restarts from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage: the sweep zeroes one entry per clock; later ports overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_valid[k]) begin
                    mem_q[waddr_a[k]] <= wdata_a[k];
                end
            end
        end
    end

    // Read ports: zero until usable, x0 and out-of-range read 0, optional same-cycle forwarding.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            raddr_a[j] = raddr[j*AW +: AW];
            rd_val[j]  = '0;
            rd_hit[j]  = 1'b0;
            if (run && addr_ok(raddr_a[j]) && !is_zero(raddr_a[j])) begin
                rd_val[j] = mem_q[raddr_a[j]];
                for (int k = 0; k < NWR; k++) begin
                    if ((BYPASS != 0) && wr_valid[k] && (waddr_a[k] == raddr_a[j])) begin
                        rd_val[j] = wdata_a[k];
                        rd_hit[j] = 1'b1;
                    end
                end
                rbusy[j] = busy_q[raddr_a[j]] & ~rd_hit[j];
            end
            rdata[j*XLEN +: XLEN] = rd_val[j];
        end
    end

endmodule

// File: tb/tb_rtl_regfile_sb.sv
// tb/tb_rtl_regfile_sb.sv - randomized self-checking bench for rtl_regfile_sb

module tb_rtl_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                init_done;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                sb_set;
    logic [AW-1:0]       sb_set_addr;
    logic [NREG-1:0]     busy_vec;
    logic                wr_conflict;

    always #5 clk = ~clk;

    rtl_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .busy_vec(busy_vec), .wr_conflict(wr_conflict)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents, busy set, conflict flag, edges since reset release.
    logic [XLEN-1:0] m_mem [NREG];
    logic [NREG-1:0] m_busy;
    logic            m_conf;
    int              m_edges;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_run();
        return m_edges >= NREG;
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input int j);
        logic [AW-1:0] a;
        a = raddr[j*AW +: AW];
        if (!m_run() || a == 0) return '0;
        for (int k = NWR - 1; k >= 0; k--)
            if (we[k] && waddr[k*AW +: AW] == a) return wdata[k*XLEN +: XLEN];
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(input int j);
        logic [AW-1:0] a;
        a = raddr[j*AW +: AW];
        if (!m_run() || a == 0) return 1'b0;
        for (int k = 0; k < NWR; k++)
            if (we[k] && waddr[k*AW +: AW] == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        rst_n   = 1'b0;
        m_edges = 0;
        m_busy  = '0;
        m_conf  = 1'b0;
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge();
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        if (!m_run()) begin
            m_edges++;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                a = waddr[k*AW +: AW];
                for (int m = k + 1; m < NWR; m++) begin
                    b = waddr[m*AW +: AW];
                    if (we[k] && we[m] && a == b && a != 0) m_conf = 1'b1;
                end
            end
            for (int k = 0; k < NWR; k++) begin
                a = waddr[k*AW +: AW];
                if (we[k] && a != 0) begin
                    m_mem[a] = wdata[k*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
        end
    endtask

    task automatic sample_check();
        @(negedge clk);
        check("init_done", {63'b0, init_done}, {63'b0, m_run()});
        check("busy_vec", {32'b0, busy_vec}, {32'b0, m_busy});
        check("wr_conflict", {63'b0, wr_conflict}, {63'b0, m_conf});
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("rdata%0d", j), {32'b0, rdata[j*XLEN +: XLEN]}, {32'b0, exp_rdata(j)});
            check($sformatf("rbusy%0d", j), {63'b0, rbusy[j]}, {63'b0, exp_rbusy(j)});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = '0; waddr = '0; wdata = '0; raddr = '0; sb_set = 1'b0; sb_set_addr = '0;
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < NWR; k++) begin
            we[k] = 1'($urandom_range(0, 1));
            waddr[k*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                           : AW'($urandom_range(0, NREG - 1));
            wdata[k*XLEN +: XLEN] = $urandom;
        end
        for (int j = 0; j < NRD; j++) begin
            if ($urandom_range(0, 1) != 0)
                raddr[j*AW +: AW] = waddr[$urandom_range(0, NWR - 1)*AW +: AW];
            else
                raddr[j*AW +: AW] = AW'($urandom_range(0, NREG - 1));
        end
        sb_set      = 1'($urandom_range(0, 1));
        sb_set_addr = AW'($urandom_range(0, 7));
    endtask

    task automatic run_sweep(input string tag);
        for (int e = 1; e <= NREG; e++) begin
            rand_inputs();
            we = '1;
            sb_set = 1'b1;
            sample_check();
            check({tag, "_low"}, {63'b0, init_done}, 64'd0);
            advance();
        end
        idle_inputs();
        sample_check();
        check({tag, "_high"}, {63'b0, init_done}, 64'd1);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sample_check();
        check("reset_busy", {32'b0, busy_vec}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_sweep("sweep");

        for (int r = 0; r < NREG; r += 2) begin
            idle_inputs();
            raddr = {AW'(r + 1), AW'(r)};
            sample_check();
            advance();
        end

        idle_inputs();
        we = 2'b01; waddr[0 +: AW] = 5; wdata[0 +: XLEN] = 32'hDEADBEEF;
        sample_check();
        advance();
        idle_inputs();
        raddr[0 +: AW] = 5;
        we = 2'b01; waddr[0 +: AW] = 0; wdata[0 +: XLEN] = 32'h1234;
        sample_check();
        check("x5_read", {32'b0, rdata[0 +: XLEN]}, 64'hDEADBEEF);
        advance();
        idle_inputs();
        raddr[0 +: AW] = 0;
        sample_check();
        check("x0_read", {32'b0, rdata[0 +: XLEN]}, 64'd0);
        advance();

        idle_inputs();
        we = 2'b10; waddr[AW +: AW] = 7; wdata[XLEN +: XLEN] = 32'hA5A5A5A5; raddr[AW +: AW] = 7;
        sample_check();
        check("bypass", {32'b0, rdata[XLEN +: XLEN]}, 64'hA5A5A5A5);
        advance();

        idle_inputs();
        we = 2'b11; waddr = {AW'(3), AW'(3)}; wdata = {32'h22, 32'h11};
        sample_check();
        advance();
        idle_inputs();
        raddr[0 +: AW] = 3;
        sb_set = 1'b1; sb_set_addr = 9;
        sample_check();
        check("conflict_data", {32'b0, rdata[0 +: XLEN]}, 64'h22);
        check("conflict_flag", {63'b0, wr_conflict}, 64'd1);
        advance();

        idle_inputs();
        raddr[0 +: AW] = 9;
        sample_check();
        check("sb_busy_vec", {63'b0, busy_vec[9]}, 64'd1);
        check("sb_rbusy", {63'b0, rbusy[0]}, 64'd1);
        advance();
        idle_inputs();
        we = 2'b01; waddr[0 +: AW] = 9; wdata[0 +: XLEN] = 32'h99; sb_set = 1'b1; sb_set_addr = 9;
        sample_check();
        advance();
        idle_inputs();
        sample_check();
        check("sb_set_wins", {63'b0, busy_vec[9]}, 64'd1);
        we = 2'b10; waddr[AW +: AW] = 9; wdata[XLEN +: XLEN] = 32'h98;
        advance();
        idle_inputs();
        sample_check();
        check("sb_cleared", {63'b0, busy_vec[9]}, 64'd0);
        advance();

        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            sample_check();
            advance();
        end
        idle_inputs();
        sample_check();
        check("conflict_sticky", {63'b0, wr_conflict}, 64'd1);

        model_reset();
        sample_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            rand_inputs();
            sample_check();
            advance();
        end
        model_reset();
        sample_check();
        check("midreset_conflict", {63'b0, wr_conflict}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_sweep("resweep");

        for (int i = 0; i < 150; i++) begin
            rand_inputs();
            sample_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
